// File: rtl/ifu_fetch_buf.sv
// Instruction-fetch front end: PC register, credit-limited in-order fetch requests,
// response FIFO toward the decoder, and redirect flush with stale-response dropping.
module ifu_fetch_buf #(
  parameter int                 PC_ADDR    = 32,
  parameter int                 DATA_WIDTH = 32,
  parameter logic [PC_ADDR-1:0] RESET_PC   = 32'h8000_0000,
  parameter int                 FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [PC_ADDR-1:0]    req_addr,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [PC_ADDR-1:0]    inst_pc_o,
  input  logic                  jump_flag,
  input  logic [PC_ADDR-1:0]    jump_addr
);

  localparam int                 AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                 CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW-1:0]      PTR_ONE = AW'(1);
  localparam logic [CW-1:0]      CNT_ONE = CW'(1);
  localparam logic [CW-1:0]      CNT_MAX = CW'(FIFO_DEPTH);
  localparam logic [PC_ADDR-1:0] PC_STEP = PC_ADDR'(4);

  logic [PC_ADDR-1:0] pc_reg, pc_next;
  logic [CW-1:0]      out_cnt_reg, out_cnt_next;
  logic [CW-1:0]      drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0]      fifo_cnt_reg, fifo_cnt_next;
  logic [AW-1:0]      tag_wr_ptr_reg, tag_wr_ptr_next;
  logic [AW-1:0]      tag_rd_ptr_reg, tag_rd_ptr_next;
  logic [AW-1:0]      fifo_wr_ptr_reg, fifo_wr_ptr_next;
  logic [AW-1:0]      fifo_rd_ptr_reg, fifo_rd_ptr_next;

  logic [PC_ADDR-1:0]    tag_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem [FIFO_DEPTH];
  logic [PC_ADDR-1:0]    pc_mem   [FIFO_DEPTH];

  logic [CW-1:0]      occupancy;
  logic               req_fire;
  logic               rsp_fire;
  logic               rsp_push;
  logic               inst_pop;
  logic [PC_ADDR-1:0] rsp_tag;
  logic               unused_jump_lsbs;

  assign unused_jump_lsbs = ^jump_addr[1:0];

  // A response with nothing outstanding is a protocol error and is ignored.
  always_comb begin
    occupancy  = out_cnt_reg + fifo_cnt_reg;
    req_valid  = !rst && !jump_flag && (occupancy < CNT_MAX);
    req_fire   = req_valid && req_ready;
    rsp_fire   = rsp_valid && (out_cnt_reg != '0);
    rsp_push   = rsp_fire && !jump_flag && (drop_cnt_reg == '0);
    inst_valid = (fifo_cnt_reg != '0);
    inst_pop   = inst_valid && inst_ready && !jump_flag;
    rsp_tag    = tag_mem[tag_rd_ptr_reg];
  end

  assign req_addr  = pc_reg;
  assign inst_o    = inst_valid ? inst_mem[fifo_rd_ptr_reg] : '0;
  assign inst_pc_o = inst_valid ? pc_mem[fifo_rd_ptr_reg]   : '0;

  always_comb begin
    pc_next          = pc_reg;
    out_cnt_next     = out_cnt_reg;
    drop_cnt_next    = drop_cnt_reg;
    fifo_cnt_next    = fifo_cnt_reg;
    tag_wr_ptr_next  = tag_wr_ptr_reg;
    tag_rd_ptr_next  = tag_rd_ptr_reg;
    fifo_wr_ptr_next = fifo_wr_ptr_reg;
    fifo_rd_ptr_next = fifo_rd_ptr_reg;

    if (req_fire) begin
      pc_next         = pc_reg + PC_STEP;
      tag_wr_ptr_next = tag_wr_ptr_reg + PTR_ONE;
    end
    if (rsp_fire) begin
      tag_rd_ptr_next = tag_rd_ptr_reg + PTR_ONE;
    end
    case ({req_fire, rsp_fire})
      2'b10:   out_cnt_next = out_cnt_reg + CNT_ONE;
      2'b01:   out_cnt_next = out_cnt_reg - CNT_ONE;
      default: out_cnt_next = out_cnt_reg;
    endcase

    if (jump_flag) begin
      // Every slot still in flight belongs to the old path, except one returning now.
      pc_next          = {jump_addr[PC_ADDR-1:2], 2'b00};
      drop_cnt_next    = rsp_fire ? (out_cnt_reg - CNT_ONE) : out_cnt_reg;
      fifo_cnt_next    = '0;
      fifo_wr_ptr_next = '0;
      fifo_rd_ptr_next = '0;
    end else begin
      if (rsp_fire && (drop_cnt_reg != '0)) begin
        drop_cnt_next = drop_cnt_reg - CNT_ONE;
      end
      if (rsp_push) begin
        fifo_wr_ptr_next = fifo_wr_ptr_reg + PTR_ONE;
      end
      if (inst_pop) begin
        fifo_rd_ptr_next = fifo_rd_ptr_reg + PTR_ONE;
      end
      case ({rsp_push, inst_pop})
        2'b10:   fifo_cnt_next = fifo_cnt_reg + CNT_ONE;
        2'b01:   fifo_cnt_next = fifo_cnt_reg - CNT_ONE;
        default: fifo_cnt_next = fifo_cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      out_cnt_reg     <= '0;
      drop_cnt_reg    <= '0;
      fifo_cnt_reg    <= '0;
      tag_wr_ptr_reg  <= '0;
      tag_rd_ptr_reg  <= '0;
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
    end else begin
      pc_reg          <= pc_next;
      out_cnt_reg     <= out_cnt_next;
      drop_cnt_reg    <= drop_cnt_next;
      fifo_cnt_reg    <= fifo_cnt_next;
      tag_wr_ptr_reg  <= tag_wr_ptr_next;
      tag_rd_ptr_reg  <= tag_rd_ptr_next;
      fifo_wr_ptr_reg <= fifo_wr_ptr_next;
      fifo_rd_ptr_reg <= fifo_rd_ptr_next;
    end
  end

  // Storage needs no reset: pointers and counts define which entries are live.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_mem[tag_wr_ptr_reg] <= pc_reg;
    end
    if (rsp_push) begin
      inst_mem[fifo_wr_ptr_reg] <= rsp_data;
      pc_mem[fifo_wr_ptr_reg]   <= rsp_tag;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_buf.sv
// Randomised and directed checks of ifu_fetch_buf against a queue-based model
// of in-flight fetches, stale-path marking and the delivered instruction stream.
module tb_ifu_fetch_buf;
  localparam int          PA      = 32;
  localparam int          DW      = 32;
  localparam int          DEPTH   = 2;
  localparam logic [31:0] RPC     = 32'h8000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_ready, rsp_valid, inst_valid, inst_ready, jump_flag;
  logic [31:0] req_addr, rsp_data, inst_o, inst_pc_o, jump_addr;
  logic        w_rst, w_req_valid, w_req_ready, w_rsp_valid, w_inst_valid, w_inst_ready, w_jump_flag;
  logic [31:0] w_req_addr, w_rsp_data, w_inst_o, w_inst_pc_o, w_jump_addr;

  ifu_fetch_buf #(.PC_ADDR(PA), .DATA_WIDTH(DW), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .jump_flag(jump_flag), .jump_addr(jump_addr)
  );

  ifu_fetch_buf #(.PC_ADDR(PA), .DATA_WIDTH(DW), .RESET_PC(WRAP_PC), .FIFO_DEPTH(4)) dut_wrap (
    .clk(clk), .rst(w_rst), .req_valid(w_req_valid), .req_ready(w_req_ready), .req_addr(w_req_addr),
    .rsp_valid(w_rsp_valid), .rsp_data(w_rsp_data), .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
    .inst_o(w_inst_o), .inst_pc_o(w_inst_pc_o), .jump_flag(w_jump_flag), .jump_addr(w_jump_addr)
  );

  typedef struct {logic [31:0] addr; bit live;} fl_t;
  typedef struct {logic [31:0] addr; int due;} mr_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int proto_err = 0;
  int lat_min = 1;
  int lat_max = 1;

  fl_t         inflight[$];
  logic [31:0] outq[$];
  mr_t         memq[$];
  logic [31:0] got_q[$];
  logic [31:0] m_pc;

  logic        o_req_valid, o_inst_valid, e_req_valid, e_inst_valid;
  logic [31:0] o_req_addr, o_inst, o_inst_pc, e_req_addr, e_inst_pc;

  // One clock: sample at negedge, advance the model and the memory, drive responses after the edge.
  task automatic step();
    fl_t         hd;
    mr_t         mr;
    bit          live;
    logic [31:0] tag;
    @(negedge clk);
    cyc++;
    o_req_valid  = req_valid;
    o_req_addr   = req_addr;
    o_inst_valid = inst_valid;
    o_inst       = inst_o;
    o_inst_pc    = inst_pc_o;
    e_inst_valid = (outq.size() != 0);
    e_inst_pc    = e_inst_valid ? outq[0] : 32'h0;
    e_req_valid  = !rst && !jump_flag && ((inflight.size() + outq.size()) < DEPTH);
    e_req_addr   = m_pc;
    if (o_inst_valid && inst_ready && !jump_flag && !rst) got_q.push_back(o_inst_pc);
    if (rst) begin
      inflight.delete();
      outq.delete();
      memq.delete();
      m_pc = RPC;
    end else begin
      live = 1'b0;
      tag  = 32'h0;
      if (rsp_valid && inflight.size() == 0) begin
        proto_err++;
        $display("protocol: rsp_valid with nothing outstanding at cycle %0d", cyc);
      end else if (rsp_valid) begin
        hd   = inflight.pop_front();
        live = hd.live && !jump_flag;
        tag  = hd.addr;
      end
      if (jump_flag) begin
        outq.delete();
        foreach (inflight[i]) inflight[i].live = 1'b0;
        m_pc = {jump_addr[31:2], 2'b00};
      end else begin
        if (inst_ready && outq.size() != 0) void'(outq.pop_front());
        if (e_req_valid && req_ready) begin
          inflight.push_back('{m_pc, 1'b1});
          m_pc = m_pc + 32'd4;
        end
      end
      if (live) outq.push_back(tag);
      if (req_valid && req_ready) begin
        mr.addr = req_addr;
        mr.due  = cyc + int'($urandom_range(lat_max, lat_min));
        memq.push_back(mr);
      end
    end
    @(posedge clk);
    #1;
    if (!rst && memq.size() != 0 && memq[0].due <= cyc + 1) begin
      mr        = memq.pop_front();
      rsp_valid = 1'b1;
      rsp_data  = mr.addr;
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    jump_flag = 1'b0;
    step();
    step();
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic test_reset();
    #2;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", req_valid); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
    total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL reset_inst_o got=%h exp=0", inst_o); end
    total++; if (inst_pc_o !== 32'h0) begin bad++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc_o); end
    req_ready = 1'b1;
    step();
    step();
    total++; if (o_req_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_req_valid got=%b exp=0", o_req_valid); end
    rst        = 1'b0;
    inst_ready = 1'b1;
    step();
    total++; if (o_req_valid !== 1'b1) begin bad++; $display("FAIL reset_first_req got=%b exp=1", o_req_valid); end
    total++; if (o_req_addr !== RPC) begin bad++; $display("FAIL reset_first_addr got=%h exp=%h", o_req_addr, RPC); end
  endtask

  task automatic test_stream();
    lat_min = 1; lat_max = 1;
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      total++; if (o_req_valid !== e_req_valid) begin bad++; $display("FAIL stream_req_valid cyc=%0d got=%b exp=%b", cyc, o_req_valid, e_req_valid); end
      if (e_req_valid) begin
        total++; if (o_req_addr !== e_req_addr) begin bad++; $display("FAIL stream_req_addr cyc=%0d got=%h exp=%h", cyc, o_req_addr, e_req_addr); end
      end
      total++; if (o_inst_valid !== e_inst_valid) begin bad++; $display("FAIL stream_inst_valid cyc=%0d got=%b exp=%b", cyc, o_inst_valid, e_inst_valid); end
      if (e_inst_valid) begin
        total++; if (o_inst_pc !== e_inst_pc) begin bad++; $display("FAIL stream_inst_pc cyc=%0d got=%h exp=%h", cyc, o_inst_pc, e_inst_pc); end
        total++; if (o_inst !== e_inst_pc) begin bad++; $display("FAIL stream_inst cyc=%0d got=%h exp=%h", cyc, o_inst, e_inst_pc); end
      end
    end
    total++; if (got_q.size() < 4) begin bad++; $display("FAIL stream_count got=%0d exp>=4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      total++; if (got_q[i] !== RPC + 32'(4 * i)) begin bad++; $display("FAIL stream_seq idx=%0d got=%h exp=%h", i, got_q[i], RPC + 32'(4 * i)); end
    end
  endtask

  task automatic test_backpressure();
    int n_fire;
    lat_min = 1; lat_max = 1;
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b0;
    n_fire = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (o_req_valid && req_ready) n_fire++;
    end
    total++; if (n_fire != 2) begin bad++; $display("FAIL bp_req_count got=%0d exp=2", n_fire); end
    total++; if (o_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_valid got=%b exp=0", o_req_valid); end
    total++; if (o_inst_valid !== 1'b1) begin bad++; $display("FAIL bp_inst_valid got=%b exp=1", o_inst_valid); end
    total++; if (o_inst_pc !== RPC) begin bad++; $display("FAIL bp_inst_pc got=%h exp=%h", o_inst_pc, RPC); end
    got_q.delete();
    inst_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();
    total++; if (got_q.size() < 3) begin bad++; $display("FAIL bp_resume_count got=%0d exp>=3", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== RPC + 32'(4 * i)) begin bad++; $display("FAIL bp_resume_seq idx=%0d got=%h exp=%h", i, got_q[i], RPC + 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect();
    bit          found;
    int          old_seen;
    logic [31:0] first;
    lat_min = 3; lat_max = 3;
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b1;
    step();
    step();
    jump_flag = 1'b1; jump_addr = 32'h8000_1002;
    step();
    total++; if (o_req_valid !== 1'b0) begin bad++; $display("FAIL redir_req_in_jump got=%b exp=0", o_req_valid); end
    jump_flag = 1'b0;
    found = 1'b0; first = 32'h0; old_seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (!found && o_req_valid && req_ready) begin found = 1'b1; first = o_req_addr; end
      if (o_inst_valid && o_inst_pc < 32'h8000_1000) old_seen++;
      total++; if (o_inst_valid !== e_inst_valid) begin bad++; $display("FAIL redir_inst_valid cyc=%0d got=%b exp=%b", cyc, o_inst_valid, e_inst_valid); end
    end
    total++; if (!found || first !== 32'h8000_1000) begin bad++; $display("FAIL redir_first_req got=%h exp=80001000", first); end
    total++; if (old_seen != 0) begin bad++; $display("FAIL redir_stale_seen got=%0d exp=0", old_seen); end
    total++; if (got_q.size() == 0 || got_q[0] !== 32'h8000_1000) begin bad++; $display("FAIL redir_first_inst got=%h exp=80001000", (got_q.size() != 0) ? got_q[0] : 32'h0); end
  endtask

  task automatic test_redirect_rsp_same_cycle();
    bit hit;
    int old_seen;
    lat_min = 3; lat_max = 3;
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (rsp_valid) begin hit = 1'b1; break; end
    end
    total++; if (!hit) begin bad++; $display("FAIL redir_rsp_wait got=timeout exp=rsp_valid"); end
    jump_flag = 1'b1; jump_addr = 32'h8000_2000;
    step();
    total++; if (o_inst_valid !== 1'b0) begin bad++; $display("FAIL redir_rsp_inst_valid got=%b exp=0", o_inst_valid); end
    jump_flag = 1'b0;
    old_seen = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (o_inst_valid && (o_inst_pc < 32'h8000_2000 || o_inst_pc >= 32'h8000_3000)) old_seen++;
      total++; if (o_inst_valid !== e_inst_valid) begin bad++; $display("FAIL redir_rsp_valid_seq cyc=%0d got=%b exp=%b", cyc, o_inst_valid, e_inst_valid); end
    end
    total++; if (old_seen != 0) begin bad++; $display("FAIL redir_rsp_stale_seen got=%0d exp=0", old_seen); end
    total++; if (got_q.size() == 0 || got_q[0] !== 32'h8000_2000) begin bad++; $display("FAIL redir_rsp_first_inst got=%h exp=80002000", (got_q.size() != 0) ? got_q[0] : 32'h0); end
  endtask

  task automatic test_wrap();
    bit          fire;
    logic [31:0] faddr, exp_req, exp_inst;
    int          n_req;
    w_req_ready = 1'b1; w_inst_ready = 1'b1; w_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    w_rst = 1'b0;
    exp_req = WRAP_PC; exp_inst = WRAP_PC; n_req = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      fire  = w_req_valid && w_req_ready;
      faddr = w_req_addr;
      if (fire) begin
        total++; if (faddr !== exp_req) begin bad++; $display("FAIL wrap_req_addr c=%0d got=%h exp=%h", c, faddr, exp_req); end
        exp_req = exp_req + 32'd4;
        n_req++;
      end
      if (c >= 2) begin
        total++; if (w_inst_valid !== 1'b1) begin bad++; $display("FAIL wrap_throughput c=%0d got=%b exp=1", c, w_inst_valid); end
        if (w_inst_valid) begin
          total++; if (w_inst_pc_o !== exp_inst || w_inst_o !== exp_inst) begin bad++; $display("FAIL wrap_inst c=%0d got=%h/%h exp=%h", c, w_inst_pc_o, w_inst_o, exp_inst); end
          exp_inst = exp_inst + 32'd4;
        end
      end
      @(posedge clk);
      #1;
      w_rsp_valid = fire;
      w_rsp_data  = faddr;
    end
    total++; if (n_req != 10) begin bad++; $display("FAIL wrap_req_count got=%0d exp=10", n_req); end
    w_rst = 1'b1;
    w_rsp_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    int p0;
    lat_min = 2; lat_max = 2;
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    #1;
    rst = 1'b1;
    #1;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL arst_req_valid got=%b exp=0", req_valid); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL arst_inst_valid got=%b exp=0", inst_valid); end
    total++; if (inst_pc_o !== 32'h0) begin bad++; $display("FAIL arst_inst_pc got=%h exp=0", inst_pc_o); end
    step();
    step();
    rst = 1'b0;
    got_q.delete();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = 32'hDEAD_BEEC;
    p0 = proto_err;
    step();
    total++; if (proto_err - p0 != 1) begin bad++; $display("FAIL arst_stale_flag got=%0d exp=1", proto_err - p0); end
    total++; if (o_req_valid !== 1'b1 || o_req_addr !== RPC) begin bad++; $display("FAIL arst_restart got=%b/%h exp=1/%h", o_req_valid, o_req_addr, RPC); end
    req_ready = 1'b1;
    step();
    total++; if (o_inst_valid !== 1'b0) begin bad++; $display("FAIL arst_stale_ignored got=%b exp=0", o_inst_valid); end
    total++; if (o_req_addr !== RPC) begin bad++; $display("FAIL arst_pc_hold got=%h exp=%h", o_req_addr, RPC); end
    for (int k = 0; k < 6; k++) step();
    total++; if (got_q.size() == 0 || got_q[0] !== RPC) begin bad++; $display("FAIL arst_first_inst got=%h exp=%h", (got_q.size() != 0) ? got_q[0] : 32'h0, RPC); end
  endtask

  task automatic test_random();
    int p0;
    lat_min = 1; lat_max = 4;
    do_reset();
    p0 = proto_err;
    for (int k = 0; k < 400; k++) begin
      req_ready  = ($urandom_range(3, 0) != 0);
      inst_ready = ($urandom_range(9, 0) < 7);
      jump_flag  = ($urandom_range(19, 0) == 0);
      jump_addr  = {16'h8000, 16'($urandom)};
      step();
      total++; if (o_req_valid !== e_req_valid) begin bad++; $display("FAIL rand_req_valid cyc=%0d got=%b exp=%b", cyc, o_req_valid, e_req_valid); end
      if (e_req_valid) begin
        total++; if (o_req_addr !== e_req_addr) begin bad++; $display("FAIL rand_req_addr cyc=%0d got=%h exp=%h", cyc, o_req_addr, e_req_addr); end
      end
      total++; if (o_inst_valid !== e_inst_valid) begin bad++; $display("FAIL rand_inst_valid cyc=%0d got=%b exp=%b", cyc, o_inst_valid, e_inst_valid); end
      if (e_inst_valid) begin
        total++; if (o_inst_pc !== e_inst_pc || o_inst !== e_inst_pc) begin bad++; $display("FAIL rand_inst cyc=%0d got=%h/%h exp=%h", cyc, o_inst_pc, o_inst, e_inst_pc); end
      end
    end
    jump_flag = 1'b0;
    total++; if (proto_err != p0) begin bad++; $display("FAIL rand_protocol got=%0d exp=%0d", proto_err, p0); end
  endtask

  initial begin
    rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'h0;
    inst_ready = 1'b0; jump_flag = 1'b0; jump_addr = 32'h0;
    w_rst = 1'b1; w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = 32'h0;
    w_inst_ready = 1'b0; w_jump_flag = 1'b0; w_jump_addr = 32'h0;
    m_pc = RPC;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_rsp_same_cycle();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
